// File: rtl/arquitetura_result_pio_in.sv
// Avalon-MM input PIO: synchronizes a fabric result bus, captures per-bit edges
// into a W1C register and raises a maskable level interrupt.
module arquitetura_result_pio_in #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;
    localparam logic [2:0] ARM_DONE  = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [2:0]                        r_arm_cnt;
    logic [WIDTH-1:0]                  r_irq_mask;
    logic [WIDTH-1:0]                  r_edge_cap;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_armed;
    logic             w_wr;
    logic [31:0]      w_rd_mux;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_armed = (r_arm_cnt == ARM_DONE);
    assign w_wr    = chipselect & ~write_n;
    assign w_clr   = (w_wr && address == ADDR_CAP) ? writedata[WIDTH-1:0] : '0;

    generate
        if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge = ~w_sync & r_prev;
        end else if (EDGE_TYPE == 2) begin : g_any
            assign w_edge = w_sync ^ r_prev;
        end else begin : g_rise
            assign w_edge = w_sync & ~r_prev;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_prev <= w_sync;
        end
    end

    // Edges are ignored until the synchronizer has flushed its reset zeros,
    // so a bus already high at reset release is not seen as a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arm_cnt <= '0;
        end else if (r_arm_cnt != ARM_DONE) begin
            r_arm_cnt <= r_arm_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_mask <= '0;
        end else if (w_wr && address == ADDR_MASK) begin
            r_irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // A new edge wins over a simultaneous write-one-to-clear of the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | (w_armed ? w_edge : '0);
        end
    end

    // Read latency 1: readdata follows address every cycle regardless of chipselect.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_sync;
            ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
            ADDR_CAP:  w_rd_mux[WIDTH-1:0] = r_edge_cap;
            default:   w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd_mux;
        end
    end

    assign irq = |(r_edge_cap & r_irq_mask);

endmodule
